// File: rtl/parity_rx.sv
// Serial odd-parity frame receiver: shifts in DATA_W data bits LSB first plus a
// trailing parity bit, presents the word, flags parity failures and counts them.
module parity_rx #(
    parameter int DATA_W = 3,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              rx_valid,
    input  logic              rx_bit,
    output logic              busy,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              parity_err,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [1:0]        dbg_state
);

    // Handshake: a bit is consumed on a rising edge where rx_valid=1 and clr=0;
    // there is no backpressure, and out_valid is a single-cycle completion pulse.

    localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PAR  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [CW-1:0]     cnt;
    logic [DATA_W-1:0] shreg;
    logic              acc;
    logic              frame_err;

    // Shifting in at the top means the first bit ends up in bit 0 after DATA_W bits.
    function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] cur,
                                                   input logic b);
        logic [DATA_W-1:0] t;
        t = cur >> 1;
        t[DATA_W-1] = b;
        return t;
    endfunction

    assign frame_err = ~(acc ^ rx_bit);
    assign busy      = (state != IDLE);
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (clr) begin
            state_nx = IDLE;
        end else if (rx_valid) begin
            case (state)
                IDLE:    state_nx = (DATA_W == 1) ? PAR : DATA;
                DATA:    state_nx = (cnt == LAST) ? PAR : DATA;
                PAR:     state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt        <= '0;
            shreg      <= '0;
            acc        <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            parity_err <= 1'b0;
            err_cnt    <= '0;
        end else begin
            out_valid <= 1'b0;
            if (clr) begin
                cnt <= '0;
                acc <= 1'b0;
            end else if (rx_valid) begin
                case (state)
                    IDLE: begin
                        shreg <= shift_in('0, rx_bit);
                        acc   <= rx_bit;
                        cnt   <= CW'(1);
                    end
                    DATA: begin
                        shreg <= shift_in(shreg, rx_bit);
                        acc   <= acc ^ rx_bit;
                        cnt   <= cnt + 1'b1;
                    end
                    PAR: begin
                        out_valid  <= 1'b1;
                        out_data   <= shreg;
                        parity_err <= frame_err;
                        if (frame_err && (err_cnt != '1)) err_cnt <= err_cnt + 1'b1;
                        acc <= 1'b0;
                        cnt <= '0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_parity_rx.sv
// Directed and randomized bench for parity_rx (DATA_W=3, CNT_W=8) with a
// count-the-ones reference model and an expected-result queue.
module tb_parity_rx;

    localparam int DATA_W  = 3;
    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk;
    logic              rst_n;
    logic              clr;
    logic              rx_valid;
    logic              rx_bit;
    logic              busy;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              parity_err;
    logic [CNT_W-1:0]  err_cnt;
    logic [1:0]        dbg_state;

    int tests = 0;
    int fails = 0;
    int exp_cnt = 0;
    logic [DATA_W-1:0] last_data = '0;
    logic              last_err = 1'b0;
    logic [DATA_W:0]   exp_q[$];

    parity_rx #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .rx_valid(rx_valid), .rx_bit(rx_bit),
        .busy(busy), .out_valid(out_valid), .out_data(out_data),
        .parity_err(parity_err), .err_cnt(err_cnt), .dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; drives inputs, passes one rising edge, returns at the next falling edge.
    task automatic step(input logic v, input logic b, input logic c);
        rx_valid = v;
        rx_bit   = b;
        clr      = c;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_data"}, out_data, 0);
        chk({tag, "_err"}, parity_err, 0);
        chk({tag, "_cnt"}, err_cnt, 0);
        chk({tag, "_state"}, dbg_state, 0);
    endtask

    task automatic send_frame(input logic [DATA_W-1:0] d, input logic p, input int maxgap);
        logic [DATA_W:0] bits;
        logic [DATA_W:0] e;
        bits = {p, d};
        // A frame is good when its total number of ones (data + parity) is odd.
        exp_q.push_back({($countones(bits) % 2) == 0, d});
        for (int i = 0; i <= DATA_W; i++) begin
            int g;
            g = $urandom_range(0, maxgap);
            repeat (g) begin
                step(1'b0, 1'($urandom), 1'b0);
                chk("gap_busy", busy, (i > 0) ? 1 : 0);
                chk("gap_valid", out_valid, 0);
            end
            step(1'b1, bits[i], 1'b0);
            if (i < DATA_W) begin
                chk("bit_busy", busy, 1);
                chk("bit_valid", out_valid, 0);
            end else begin
                e = exp_q.pop_front();
                if (e[DATA_W] && exp_cnt < CNT_MAX) exp_cnt++;
                last_data = e[DATA_W-1:0];
                last_err  = e[DATA_W];
                chk("done_valid", out_valid, 1);
                chk("done_data", out_data, e[DATA_W-1:0]);
                chk("done_err", parity_err, e[DATA_W]);
                chk("done_cnt", err_cnt, exp_cnt);
                chk("done_busy", busy, 0);
            end
        end
    endtask

    initial begin
        logic [DATA_W-1:0] d;
        rst_n = 1'b0; clr = 1'b0; rx_valid = 1'b0; rx_bit = 1'b0;
        @(negedge clk);
        step(1'b1, 1'b1, 1'b0);
        chk_zero("reset");
        rst_n = 1'b1;

        // Good frame 101 with parity 1, no gaps
        send_frame(3'b101, 1'b1, 0);
        step(1'b0, 1'b0, 1'b0);
        chk("pulse_one_cycle", out_valid, 0);
        chk("hold_data", out_data, 3'b101);
        chk("hold_err", parity_err, 0);

        // Bad frame then good frame of zeros
        send_frame(3'b101, 1'b0, 0);
        chk("bad_cnt", err_cnt, 1);
        send_frame(3'b000, 1'b1, 0);
        chk("good_after_bad_cnt", err_cnt, 1);

        // Random frames with gaps
        for (int n = 0; n < 100; n++)
            send_frame(DATA_W'($urandom_range(0, (1 << DATA_W) - 1)), 1'($urandom_range(0, 1)), 5);

        // Abort after two data bits, including a bit offered alongside clr
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        chk("pre_clr_busy", busy, 1);
        step(1'b0, 1'b0, 1'b1);
        chk("clr_busy", busy, 0);
        chk("clr_valid", out_valid, 0);
        chk("clr_data_held", out_data, last_data);
        chk("clr_err_held", parity_err, last_err);
        chk("clr_cnt", err_cnt, exp_cnt);
        step(1'b1, 1'b1, 1'b1);
        chk("clr_bit_dropped", busy, 0);
        repeat (3) begin
            step(1'b0, 1'b0, 1'b0);
            chk("clr_no_valid", out_valid, 0);
        end
        send_frame(3'b110, 1'b1, 2);

        // Saturation with 300 back-to-back bad frames
        for (int n = 0; n < 300; n++) begin
            d = DATA_W'($urandom_range(0, (1 << DATA_W) - 1));
            send_frame(d, ^d, 0);
        end
        chk("sat_cnt", err_cnt, CNT_MAX);
        send_frame(3'b111, 1'b1, 0);
        chk("sat_stays", err_cnt, CNT_MAX);

        rst_n = 1'b0;
        step(1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        exp_cnt = 0;
        chk_zero("sat_reset");

        // Reset mid-frame, then a clean frame sent as 1,1,0 + parity 1
        step(1'b1, 1'b1, 1'b0);
        chk("mid_busy", busy, 1);
        rst_n = 1'b0;
        step(1'b1, 1'b0, 1'b0);
        rst_n = 1'b1;
        chk_zero("mid_reset");
        send_frame(3'b011, 1'b1, 0);
        chk("lsb_first_data", out_data, 3'b011);
        chk("lsb_first_err", parity_err, 0);

        step(1'b0, 1'b0, 1'b0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
